// File: rtl/micro_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : micro_datapath
//  Purpose  : 4-bit accumulator datapath driven by decoded control strobes
//             C0-C12; A/B registers, 4-op ALU, Z/CY flags, OUT register.
//  Revision : 1.0  initial release
// ============================================================================
module micro_datapath (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       C0,
    input  logic       C1,
    input  logic       C2,
    input  logic       C3,
    input  logic       C4,
    input  logic       C5,
    input  logic       C6,
    input  logic       C7,
    input  logic       C8,
    input  logic       C9,
    input  logic       C10,
    input  logic       C11,
    input  logic       C12,
    input  logic [3:0] data_in,
    output logic       flag,
    output logic [3:0] data_out,
    output logic       out_valid
);

    localparam logic [1:0] c_ALU_ADD = 2'b00;
    localparam logic [1:0] c_ALU_SUB = 2'b01;
    localparam logic [1:0] c_ALU_AND = 2'b10;
    localparam logic [1:0] c_ALU_XOR = 2'b11;

    logic [3:0] r_a;
    logic [3:0] r_b;
    logic [3:0] r_out;
    logic       r_z;
    logic       r_cy;
    logic       r_out_valid;

    logic [1:0] w_alu_sel;
    logic [4:0] w_sum;
    logic [4:0] w_diff;
    logic [3:0] w_alu_res;
    logic       w_alu_cy;
    logic       w_alu_z;
    logic [3:0] w_a_next;
    logic [3:0] w_b_next;
    logic       w_swap_ok;

    assign w_alu_sel = {C4, C3};
    assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
    // Bit 4 of the 5-bit difference is set exactly when A < B (borrow).
    assign w_diff    = {1'b0, r_a} - {1'b0, r_b};

    always_comb begin
        w_alu_res = 4'd0;
        w_alu_cy  = 1'b0;
        case (w_alu_sel)
            c_ALU_ADD: begin
                w_alu_res = w_sum[3:0];
                w_alu_cy  = w_sum[4];
            end
            c_ALU_SUB: begin
                w_alu_res = w_diff[3:0];
                w_alu_cy  = w_diff[4];
            end
            c_ALU_AND: w_alu_res = r_a & r_b;
            c_ALU_XOR: w_alu_res = r_a ^ r_b;
            default: begin
                w_alu_res = 4'd0;
                w_alu_cy  = 1'b0;
            end
        endcase
    end

    assign w_alu_z = (w_alu_res == 4'd0);

    // A swap only reaches B when it also wins the A priority chain.
    assign w_swap_ok = C10 && !(C6 || C0 || C2);

    always_comb begin
        w_a_next = r_a;
        if (C6)
            w_a_next = 4'd0;
        else if (C0)
            w_a_next = data_in;
        else if (C2)
            w_a_next = w_alu_res;
        else if (C10)
            w_a_next = r_b;
        else if (C7)
            w_a_next = r_a + 4'd1;
        else if (C8)
            w_a_next = {r_a[2:0], 1'b0};
        else if (C9)
            w_a_next = {1'b0, r_a[3:1]};
    end

    always_comb begin
        w_b_next = r_b;
        if (C1)
            w_b_next = data_in;
        else if (w_swap_ok)
            w_b_next = r_a;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_a         <= 4'd0;
            r_b         <= 4'd0;
            r_out       <= 4'd0;
            r_z         <= 1'b0;
            r_cy        <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_a         <= w_a_next;
            r_b         <= w_b_next;
            r_out_valid <= C5;
            if (C5)
                r_out <= r_a;
            if (C12) begin
                r_z  <= w_alu_z;
                r_cy <= w_alu_cy;
            end
        end
    end

    assign flag      = C11 ? r_cy : r_z;
    assign data_out  = r_out;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_micro_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_micro_datapath
//  Purpose  : Scoreboard bench for micro_datapath with directed and random
//             strobe sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_micro_datapath;

    localparam logic [12:0] c_LDA  = 13'h0001;
    localparam logic [12:0] c_LDB  = 13'h0002;
    localparam logic [12:0] c_ALU  = 13'h0004;
    localparam logic [12:0] c_SEL0 = 13'h0008;
    localparam logic [12:0] c_SEL1 = 13'h0010;
    localparam logic [12:0] c_OUT  = 13'h0020;
    localparam logic [12:0] c_CLR  = 13'h0040;
    localparam logic [12:0] c_INC  = 13'h0080;
    localparam logic [12:0] c_SHL  = 13'h0100;
    localparam logic [12:0] c_SHR  = 13'h0200;
    localparam logic [12:0] c_SWP  = 13'h0400;
    localparam logic [12:0] c_FSEL = 13'h0800;
    localparam logic [12:0] c_LAT  = 13'h1000;

    typedef struct packed {
        logic [3:0] dout;
        logic       vld;
        logic       flg;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [12:0] r_c     = 13'd0;
    logic [3:0]  data_in = 4'd0;
    logic        flag;
    logic [3:0]  data_out;
    logic        out_valid;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb_q[$];

    // Bench reference state
    logic [3:0] m_a = 4'd0, m_b = 4'd0, m_out = 4'd0;
    logic       m_z = 1'b0, m_cy = 1'b0, m_vld = 1'b0;

    always #5 sys_clk = ~sys_clk;

    micro_datapath u_dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .C0        (r_c[0]),
        .C1        (r_c[1]),
        .C2        (r_c[2]),
        .C3        (r_c[3]),
        .C4        (r_c[4]),
        .C5        (r_c[5]),
        .C6        (r_c[6]),
        .C7        (r_c[7]),
        .C8        (r_c[8]),
        .C9        (r_c[9]),
        .C10       (r_c[10]),
        .C11       (r_c[11]),
        .C12       (r_c[12]),
        .data_in   (data_in),
        .flag      (flag),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, predict, compare just after the posedge.
    task automatic step(input logic rst, input logic [12:0] c, input logic [3:0] din);
        logic [4:0] t;
        logic [3:0] res, na, nb;
        logic       cy;
        exp_t       e;
        @(negedge sys_clk);
        sys_rst = rst;
        r_c     = c;
        data_in = din;
        case ({c[4], c[3]})
            2'b00: begin t = {1'b0, m_a} + {1'b0, m_b}; res = t[3:0]; cy = t[4]; end
            2'b01: begin res = m_a - m_b; cy = (m_a < m_b); end
            2'b10: begin res = m_a & m_b; cy = 1'b0; end
            default: begin res = m_a ^ m_b; cy = 1'b0; end
        endcase
        if (c[6])       na = 4'd0;
        else if (c[0])  na = din;
        else if (c[2])  na = res;
        else if (c[10]) na = m_b;
        else if (c[7])  na = m_a + 4'd1;
        else if (c[8])  na = m_a << 1;
        else if (c[9])  na = m_a >> 1;
        else            na = m_a;
        if (c[1])                              nb = din;
        else if (c[10] && !(c[6]|c[0]|c[2]))   nb = m_a;
        else                                   nb = m_b;
        if (rst) begin
            m_a = 0; m_b = 0; m_out = 0; m_z = 0; m_cy = 0; m_vld = 0;
        end else begin
            if (c[5])  m_out = m_a;
            if (c[12]) begin m_z = (res == 4'd0); m_cy = cy; end
            m_vld = c[5];
            m_a   = na;
            m_b   = nb;
        end
        e.dout = m_out;
        e.vld  = m_vld;
        e.flg  = c[11] ? m_cy : m_z;
        sb_q.push_back(e);
        @(posedge sys_clk);
        #1;
        e = sb_q.pop_front();
        check("data_out", {4'd0, data_out}, {4'd0, e.dout});
        check("out_valid", {7'd0, out_valid}, {7'd0, e.vld});
        check("flag", {7'd0, flag}, {7'd0, e.flg});
    endtask

    task automatic load_ab(input logic [3:0] a, input logic [3:0] b);
        step(1'b0, c_LDA, a);
        step(1'b0, c_LDB, b);
    endtask

    // Copy A to OUT and compare against a fixed expected value.
    task automatic expect_a(input string tag, input logic [3:0] val);
        step(1'b0, c_OUT, 4'd0);
        check(tag, {4'd0, data_out}, {4'd0, val});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every strobe asserted
        step(1'b1, 13'h1FFF, 4'hF);
        step(1'b1, 13'h1FFF, 4'hF);
        step(1'b0, 13'd0, 4'd0);
        check("rst_flag_z", {7'd0, flag}, 8'd0);
        check("rst_out", {4'd0, data_out}, 8'd0);
        step(1'b0, c_FSEL, 4'd0);
        check("rst_flag_cy", {7'd0, flag}, 8'd0);
        expect_a("rst_a", 4'd0);

        // 9 + 8 -> 1 with carry
        load_ab(4'd9, 4'd8);
        step(1'b0, c_ALU | c_LAT, 4'd0);
        step(1'b0, c_FSEL, 4'd0);
        check("add_cy", {7'd0, flag}, 8'd1);
        step(1'b0, 13'd0, 4'd0);
        check("add_z", {7'd0, flag}, 8'd0);
        expect_a("add_a", 4'd1);

        // 3 - 5 -> 14 with borrow; 5 - 5 -> 0, Z=1, CY=0
        load_ab(4'd3, 4'd5);
        step(1'b0, c_ALU | c_SEL0 | c_LAT, 4'd0);
        expect_a("sub_a", 4'd14);
        step(1'b0, c_FSEL, 4'd0);
        check("sub_borrow", {7'd0, flag}, 8'd1);
        load_ab(4'd5, 4'd5);
        step(1'b0, c_ALU | c_SEL0 | c_LAT, 4'd0);
        check("sub0_z", {7'd0, flag}, 8'd1);
        step(1'b0, c_FSEL, 4'd0);
        check("sub0_cy", {7'd0, flag}, 8'd0);
        expect_a("sub0_a", 4'd0);

        // AND / XOR without writing A
        load_ab(4'hC, 4'h3);
        step(1'b0, c_SEL1 | c_LAT, 4'd0);
        check("and_z", {7'd0, flag}, 8'd1);
        step(1'b0, c_SEL1 | c_SEL0 | c_LAT | c_FSEL, 4'd0);
        check("xor_cy", {7'd0, flag}, 8'd0);

        // Increment wrap, shifts; flags untouched
        step(1'b0, c_LDA, 4'd15);
        step(1'b0, c_INC, 4'd0);
        expect_a("inc_wrap", 4'd0);
        step(1'b0, 13'd0, 4'd0);
        check("inc_flags", {7'd0, flag}, 8'd0);
        step(1'b0, c_LDA, 4'b1001);
        step(1'b0, c_SHL, 4'd0);
        expect_a("shl", 4'b0010);
        step(1'b0, c_LDA, 4'b1001);
        step(1'b0, c_SHR, 4'd0);
        expect_a("shr", 4'b0100);

        // Swap and its priority interactions
        load_ab(4'd6, 4'd2);
        step(1'b0, c_SWP, 4'd0);
        expect_a("swap_a", 4'd2);
        step(1'b0, c_SWP | c_LDA, 4'd7);
        expect_a("swap_void_a", 4'd7);
        step(1'b0, c_SWP | c_LDB, 4'd4);
        expect_a("swap_ldb_a", 4'd6);
        step(1'b0, c_SWP, 4'd0);
        expect_a("swap_ldb_b", 4'd4);

        // OUT gets old A while A clears; pulse then reset
        step(1'b0, c_LDA, 4'd12);
        step(1'b0, c_OUT | c_CLR, 4'd0);
        check("out_old_a", {4'd0, data_out}, 8'd12);
        check("out_pulse", {7'd0, out_valid}, 8'd1);
        step(1'b1, 13'd0, 4'd0);
        check("rst_vld", {7'd0, out_valid}, 8'd0);
        check("rst_out2", {4'd0, data_out}, 8'd0);
        step(1'b0, c_OUT, 4'd0);
        step(1'b0, c_OUT, 4'd0);
        check("b2b_vld", {7'd0, out_valid}, 8'd1);
        step(1'b0, 13'd0, 4'd0);
        check("vld_drop", {7'd0, out_valid}, 8'd0);

        // Random sparse strobes with occasional reset
        for (int i = 0; i < 400; i++) begin
            logic [12:0] rc;
            rc = 13'($urandom) & 13'($urandom) & 13'($urandom);
            step($urandom_range(0, 39) == 0, rc, 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
